photon_tag_buffer: RTL and testbench



---
 rtl/photon_tag_pkg.sv | 28 ++
 rtl/tag_fifo_fwft.sv | 66 ++++++
 rtl/photon_tag_buffer.sv | 149 ++++++++++++++
 tb/tb_photon_tag_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/photon_tag_pkg.sv
// Shared types for the photon tag buffer: FSM states, raw counter snapshot, output width helper.
// PHOTON_TAG_SEQ_EN widens each record by a 16-bit sequence field in the MSBs.
package photon_tag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int SEQ_W = 16;

  // Counter-stage snapshot at full port width; truncation happens when packing the record.
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [23:0]      start;
    logic [31:0]      stop;
  } tag_raw_t;

  function automatic int out_w(input int start_w, input int stop_w);
`ifdef PHOTON_TAG_SEQ_EN
    return SEQ_W + start_w + stop_w;
`else
    return start_w + stop_w;
`endif
  endfunction

endpackage

// File: rtl/tag_fifo_fwft.sv
// Generic first-word-fall-through FIFO; a write is visible at rd_dat one cycle later, and an empty FIFO never bypasses.
// Backpressure: wr_en is accepted when not full or when a pop shares the edge; clr overrides push and pop.
module tag_fifo_fwft #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 56
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign rd_dat = mem_q[rd_ptr_q];

  always_comb begin
    push     = wr_en && (!full || rd_en) && !clr;
    pop      = rd_en && !empty && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/photon_tag_buffer.sv
// Tags photon arrivals with cnt_start/cnt_stop inside armed frames; a tag reaches tag_data one edge after capture.
// Valid/ready output holds the head while stalled; captures into a full FIFO are dropped and counted. Option: PHOTON_TAG_SEQ_EN.
module photon_tag_buffer
  import photon_tag_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int STOP_W  = 32,
  parameter int START_W = 24,
  parameter int DROP_W  = 16
) (
  input  logic                               clk500,
  input  logic                               count_rst_n,
  input  logic                               photo,
  input  logic [31:0]                        cnt_stop,
  input  logic [23:0]                        cnt_start,
  input  logic [31:0]                        sequence_count,
  input  logic                               ready,
  input  logic                               arm,
  input  logic [15:0]                        max_tags,
  input  logic                               buf_clr,
  output logic [out_w(START_W, STOP_W)-1:0]  tag_data,
  output logic                               tag_valid,
  input  logic                               tag_ready,
  output logic [$clog2(DEPTH):0]             fifo_level,
  output logic                               frame_done,
  output logic                               overflow,
  output logic [DROP_W-1:0]                  drop_cnt
);
  localparam int OUT_W = out_w(START_W, STOP_W);

  logic              p1_q, p1_d, p2_q, p2_d, det_q, det_d, arm_q, arm_d;
  state_e            state_q, state_d;
  logic [15:0]       tag_cnt_q, tag_cnt_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              capture, rd_en, wr_en, accepted, drop;
  logic              arm_rise, arm_fall;
  logic              fifo_full, fifo_empty;
  logic [OUT_W-1:0]  wr_dat, rd_dat;
  tag_raw_t          raw;
  logic              unused_raw;

  assign raw = '{seq: sequence_count[SEQ_W-1:0], start: cnt_start, stop: cnt_stop};
  assign unused_raw = ^{raw, sequence_count[31:SEQ_W]};

`ifdef PHOTON_TAG_SEQ_EN
  assign wr_dat = {raw.seq, raw.start[START_W-1:0], raw.stop[STOP_W-1:0]};
`else
  assign wr_dat = {raw.start[START_W-1:0], raw.stop[STOP_W-1:0]};
`endif

  tag_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk    (clk500),
    .rst_n  (count_rst_n),
    .clr    (buf_clr),
    .wr_en  (wr_en),
    .wr_dat (wr_dat),
    .rd_en  (rd_en),
    .rd_dat (rd_dat),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign tag_valid  = !fifo_empty;
  assign tag_data   = tag_valid ? rd_dat : '0;
  assign frame_done = (state_q == DONE);
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

  always_comb begin
    p1_d  = photo;
    p2_d  = p1_q;
    det_d = p1_q & ~p2_q;
    arm_d = arm;

    arm_rise = arm & ~arm_q;
    arm_fall = arm_q & ~arm;
    capture  = (state_q == ARMED) && ready && det_q;
    rd_en    = tag_valid && tag_ready;
    wr_en    = capture && (!fifo_full || rd_en);
    // A flush on the same edge discards the write, so it does not count toward the frame.
    accepted = wr_en && !buf_clr;
    drop     = capture && fifo_full && !rd_en;
  end

  always_comb begin
    state_d   = state_q;
    tag_cnt_d = tag_cnt_q;
    if (accepted) tag_cnt_d = tag_cnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (arm_rise) begin
          state_d   = ARMED;
          tag_cnt_d = '0;
        end
      end
      ARMED: begin
        if (arm_fall)
          state_d = IDLE;
        else if (accepted && (max_tags != '0) && (tag_cnt_q + 16'd1 >= max_tags))
          state_d = DONE;
      end
      DONE: begin
        if (arm_fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (buf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk500) begin
    if (!count_rst_n) begin
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      det_q      <= 1'b0;
      arm_q      <= 1'b0;
      state_q    <= IDLE;
      tag_cnt_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      det_q      <= det_d;
      arm_q      <= arm_d;
      state_q    <= state_d;
      tag_cnt_q  <= tag_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_photon_tag_buffer.sv
// Directed bench for photon_tag_buffer at DEPTH=4; covers framing, gating, overflow, flush, reset and the sequence field.
module tb_photon_tag_buffer;
  import photon_tag_pkg::*;

  localparam int DEPTH = 4;
  localparam int OW    = out_w(24, 32);

  logic        clk500 = 1'b0;
  logic        count_rst_n, photo, ready, arm, buf_clr, tag_ready;
  logic [31:0] cnt_stop, sequence_count;
  logic [23:0] cnt_start;
  logic [15:0] max_tags;
  logic [OW-1:0] tag_data;
  logic        tag_valid, frame_done, overflow;
  logic [2:0]  fifo_level;
  logic [15:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #1 clk500 = ~clk500;

  photon_tag_buffer #(
    .DEPTH(DEPTH), .STOP_W(32), .START_W(24), .DROP_W(16)
  ) dut (
    .clk500(clk500), .count_rst_n(count_rst_n), .photo(photo),
    .cnt_stop(cnt_stop), .cnt_start(cnt_start), .sequence_count(sequence_count),
    .ready(ready), .arm(arm), .max_tags(max_tags), .buf_clr(buf_clr),
    .tag_data(tag_data), .tag_valid(tag_valid), .tag_ready(tag_ready),
    .fifo_level(fifo_level), .frame_done(frame_done), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  function automatic logic [OW-1:0] mk(input logic [31:0] stop, input logic [23:0] start);
`ifdef PHOTON_TAG_SEQ_EN
    return {16'hABCD, start, stop};
`else
    return {start, stop};
`endif
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counter values ramp each cycle; only the value present at the det_q edge should be captured.
  task automatic pulse(input logic [31:0] v, input logic [23:0] s, input logic rdy);
    photo = 1'b1; cnt_stop = v - 32'd2; cnt_start = s - 24'd2;
    @(negedge clk500);
    photo = 1'b0; cnt_stop = v - 32'd1; cnt_start = s - 24'd1;
    @(negedge clk500);
    cnt_stop = v; cnt_start = s; tag_ready = rdy;
    @(negedge clk500);
    cnt_stop = v + 32'd1; cnt_start = s + 24'd1; tag_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk500);
  endtask

  initial begin
    count_rst_n = 1'b0; photo = 1'b0; ready = 1'b0; arm = 1'b0; buf_clr = 1'b0;
    tag_ready = 1'b0; cnt_stop = '0; cnt_start = '0; max_tags = '0;
    sequence_count = 32'h0001_ABCD;
    idle(2);
    chk("rst_valid", 96'(tag_valid), 96'd0);
    chk("rst_level", 96'(fifo_level), 96'd0);
    chk("rst_done", 96'(frame_done), 96'd0);
    chk("rst_ovf", 96'(overflow), 96'd0);
    chk("rst_drop", 96'(drop_cnt), 96'd0);
    chk("rst_data", 96'(tag_data), 96'd0);
    count_rst_n = 1'b1;
    idle(1);

    // Frame with max_tags=3: five pulses, only three tags kept.
    max_tags = 16'd3; ready = 1'b1; arm = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) begin
      pulse(32'd100 + 32'(10 * i), 24'h10 + 24'(i), 1'b0);
      if (i == 0) begin
        chk("f1_level1", 96'(fifo_level), 96'd1);
        chk("f1_data1", 96'(tag_data), 96'(mk(32'd100, 24'h10)));
        chk("f1_notdone", 96'(frame_done), 96'd0);
`ifdef PHOTON_TAG_SEQ_EN
        chk("seq_msb", 96'(tag_data[OW-1 -: 16]), 96'hABCD);
`endif
      end
      if (i == 2) begin
        chk("f1_level3", 96'(fifo_level), 96'd3);
        chk("f1_done", 96'(frame_done), 96'd1);
        chk("f1_hold", 96'(tag_data), 96'(mk(32'd100, 24'h10)));
      end
      idle(7);
    end
    chk("f1_ignored", 96'(fifo_level), 96'd3);
    chk("f1_nodrop", 96'(drop_cnt), 96'd0);
    for (int i = 0; i < 3; i++) begin
      chk("f1_drain", 96'(tag_data), 96'(mk(32'd100 + 32'(10 * i), 24'h10 + 24'(i))));
      tag_ready = 1'b1;
      idle(1);
      tag_ready = 1'b0;
    end
    chk("f1_empty", 96'(tag_valid), 96'd0);
    arm = 1'b0;
    idle(1);
    chk("f1_disarm", 96'(frame_done), 96'd0);

    // Window closed: pulses ignored and not counted as drops.
    max_tags = 16'd0; arm = 1'b1; ready = 1'b0;
    idle(1);
    repeat (4) begin
      pulse(32'd500, 24'h50, 1'b0);
      idle(2);
    end
    chk("nr_level", 96'(fifo_level), 96'd0);
    chk("nr_drop", 96'(drop_cnt), 96'd0);

    // Six captures into a four-deep FIFO.
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse(32'd200 + 32'(10 * i), 24'h20 + 24'(i), 1'b0);
      idle(1);
    end
    chk("of_level", 96'(fifo_level), 96'd4);
    chk("of_ovf", 96'(overflow), 96'd1);
    chk("of_drop", 96'(drop_cnt), 96'd2);
    chk("of_head", 96'(tag_data), 96'(mk(32'd200, 24'h20)));

    // Capture while full with a pop on the same edge.
    pulse(32'd260, 24'h26, 1'b1);
    idle(1);
    chk("fr_level", 96'(fifo_level), 96'd4);
    chk("fr_drop", 96'(drop_cnt), 96'd2);
    for (int i = 0; i < 3; i++) begin
      chk("fr_order", 96'(tag_data), 96'(mk(32'd210 + 32'(10 * i), 24'h21 + 24'(i))));
      tag_ready = 1'b1;
      idle(1);
      tag_ready = 1'b0;
    end
    chk("fr_last", 96'(tag_data), 96'(mk(32'd260, 24'h26)));
    chk("fr_level1", 96'(fifo_level), 96'd1);

    buf_clr = 1'b1;
    idle(1);
    buf_clr = 1'b0;
    chk("clr_level", 96'(fifo_level), 96'd0);
    chk("clr_ovf", 96'(overflow), 96'd0);
    chk("clr_drop", 96'(drop_cnt), 96'd0);
    chk("clr_valid", 96'(tag_valid), 96'd0);

    // Read asserted while empty on the write edge: no bypass, tag appears next cycle.
    pulse(32'd300, 24'h30, 1'b1);
    chk("em_valid", 96'(tag_valid), 96'd1);
    chk("em_level", 96'(fifo_level), 96'd1);
    chk("em_data", 96'(tag_data), 96'(mk(32'd300, 24'h30)));
    tag_ready = 1'b1;
    idle(1);
    tag_ready = 1'b0;
    chk("em_pop", 96'(fifo_level), 96'd0);

    // Reset mid-frame with three tags queued.
    for (int i = 0; i < 3; i++) begin
      pulse(32'd400 + 32'(i), 24'h40 + 24'(i), 1'b0);
      idle(1);
    end
    chk("mr_level3", 96'(fifo_level), 96'd3);
    count_rst_n = 1'b0; arm = 1'b0;
    idle(1);
    count_rst_n = 1'b1;
    chk("mr_valid", 96'(tag_valid), 96'd0);
    chk("mr_level", 96'(fifo_level), 96'd0);
    chk("mr_data", 96'(tag_data), 96'd0);
    pulse(32'd450, 24'h45, 1'b0);
    idle(1);
    chk("mr_idle", 96'(fifo_level), 96'd0);
    arm = 1'b1;
    idle(1);
    pulse(32'd460, 24'h46, 1'b0);
    idle(1);
    chk("mr_rearm", 96'(fifo_level), 96'd1);
    chk("mr_data2", 96'(tag_data), 96'(mk(32'd460, 24'h46)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
